// File: rtl/paula_audio_mix_sched.sv
// Four-channel Paula volume scheduler: snapshots channel requests, shares one
// sample x volume multiplier round-robin, keeps per-channel products and the stereo mix.
module paula_audio_mix_sched #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  smp_req,
  input  logic [31:0] smp_in,
  input  logic [23:0] vol_in,
  input  logic [3:0]  mute,
  output logic [7:0]  mul_sample,
  output logic [5:0]  mul_volume,
  input  logic [13:0] mul_product,
  output logic [55:0] ch_out,
  output logic [14:0] left,
  output logic [14:0] right,
  output logic        mix_valid,
  output logic [3:0]  overrun
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, MIX = 2'd2} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       pend_q, ovr_q;
  logic [3:0][7:0]  snap_smp_q;
  logic [3:0][5:0]  snap_vol_q;
  logic [3:0][13:0] ch_q;
  logic [1:0]       rr_q, gnt_q, gnt_d;
  logic [7:0]       mul_smp_q;
  logic [5:0]       mul_vol_q;
  logic [14:0]      left_q, right_q;
  logic             mix_q;
  logic             issue;

  // Descending scan so the nearest pending channel after rr_q wins.
  always_comb begin
    gnt_d = rr_q;
    for (int k = 4; k >= 1; k--)
      if (pend_q[rr_q + 2'(k)]) gnt_d = rr_q + 2'(k);
  end

  assign issue = (state_q == IDLE) && (|pend_q);

  // A request landing on its own issue edge re-arms pending without counting as overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      ovr_q      <= '0;
      snap_smp_q <= '0;
      snap_vol_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (smp_req[i]) begin
          snap_smp_q[i] <= smp_in[8*i +: 8];
          snap_vol_q[i] <= vol_in[6*i +: 6];
          pend_q[i]     <= 1'b1;
          if (pend_q[i] && !(issue && gnt_d == 2'(i))) ovr_q[i] <= 1'b1;
        end else if (issue && gnt_d == 2'(i)) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= 2'd3;
      gnt_q     <= '0;
      mul_smp_q <= '0;
      mul_vol_q <= '0;
      ch_q      <= '0;
      left_q    <= '0;
      right_q   <= '0;
      mix_q     <= 1'b0;
    end else begin
      mix_q <= 1'b0;
      case (state_q)
        IDLE: if (issue) begin
          mul_smp_q <= snap_smp_q[gnt_d];
          mul_vol_q <= mute[gnt_d] ? 6'd0 : snap_vol_q[gnt_d];
          gnt_q     <= gnt_d;
          rr_q      <= gnt_d;
          cnt_q     <= CW'(MUL_LAT);
          state_q   <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            ch_q[gnt_q] <= mul_product;
            state_q     <= MIX;
          end
        end
        MIX: begin
          left_q  <= {ch_q[0][13], ch_q[0]} + {ch_q[3][13], ch_q[3]};
          right_q <= {ch_q[1][13], ch_q[1]} + {ch_q[2][13], ch_q[2]};
          mix_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_sample = mul_smp_q;
  assign mul_volume = mul_vol_q;
  assign ch_out     = ch_q;
  assign left       = left_q;
  assign right      = right_q;
  assign mix_valid  = mix_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_paula_audio_mix_sched.sv
// Bench for paula_audio_mix_sched: hand tables and sequences plus random traffic
// checked against a transaction-level scheduler model (MUL_LAT=1 and MUL_LAT=3 instances).
module tb_paula_audio_mix_sched;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic [3:0]  smp_req, mute;
  logic [31:0] smp_in;
  logic [23:0] vol_in;

  logic [7:0]  ms1, ms3;
  logic [5:0]  mvol1, mvol3;
  logic [13:0] mp1, mp3, s1_3;
  logic [55:0] co1, co3;
  logic [14:0] lf1, rt1, lf3, rt3;
  logic        mix1, mix3;
  logic [3:0]  ov1, ov3;
  int          p1, p3;

  always #5 clk = ~clk;

  paula_audio_mix_sched #(.MUL_LAT(L1)) d1 (
    .clk(clk), .reset_n(rst1), .smp_req(smp_req), .smp_in(smp_in), .vol_in(vol_in),
    .mute(mute), .mul_sample(ms1), .mul_volume(mvol1), .mul_product(mp1), .ch_out(co1),
    .left(lf1), .right(rt1), .mix_valid(mix1), .overrun(ov1));

  paula_audio_mix_sched #(.MUL_LAT(L3)) d3 (
    .clk(clk), .reset_n(rst3), .smp_req(smp_req), .smp_in(smp_in), .vol_in(vol_in),
    .mute(mute), .mul_sample(ms3), .mul_volume(mvol3), .mul_product(mp3), .ch_out(co3),
    .left(lf3), .right(rt3), .mix_valid(mix3), .overrun(ov3));

  // Shared multiplier models: combinational for latency 1, two register stages for latency 3.
  always_comb begin
    p1  = int'($signed(ms1)) * int'(mvol1);
    p3  = int'($signed(ms3)) * int'(mvol3);
    mp1 = p1[13:0];
  end
  always @(posedge clk) begin
    s1_3 <= p3[13:0];
    mp3  <= s1_3;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ch1v(input int i);
    return int'($signed(co1[14*i +: 14]));
  endfunction
  function automatic int ch3v(input int i);
    return int'($signed(co3[14*i +: 14]));
  endfunction

  // Reference model: requests enter a pending set; whenever the server is free it takes the
  // next pending channel round-robin and the result appears MUL_LAT+1 edges later.
  typedef struct {int ch; int prod; int edge_no;} ev_t;
  ev_t      evq[$];
  bit [3:0] m_pend, m_ovr;
  int       m_smp[4], m_vol[4], m_ch[4];
  int       m_rr, free_k, edge_n = 0;

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_rr = 3; free_k = 0;
    for (int i = 0; i < 4; i++) begin m_smp[i] = 0; m_vol[i] = 0; m_ch[i] = 0; end
    evq.delete();
  endtask

  task automatic model_step();
    int g;
    ev_t e;
    g = -1;
    if (edge_n >= free_k && m_pend != 0) begin
      for (int k = 1; k <= 4 && g < 0; k++)
        if (m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      e.ch = g;
      e.prod = m_smp[g] * (mute[g] ? 0 : m_vol[g]);
      e.edge_no = edge_n + L1 + 1;
      evq.push_back(e);
      m_pend[g] = 1'b0;
      m_rr = g;
      free_k = edge_n + L1 + 2;
    end
    for (int i = 0; i < 4; i++) if (smp_req[i]) begin
      if (m_pend[i]) m_ovr[i] = 1'b1;
      m_pend[i] = 1'b1;
      m_smp[i] = int'($signed(smp_in[8*i +: 8]));
      m_vol[i] = int'(vol_in[6*i +: 6]);
    end
  endtask

  // One clock: advance model across the edge, check d1 on the falling edge, drop request pulses.
  task automatic tick();
    bit exp_mv;
    ev_t e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_mv = evq.size() > 0 && evq[0].edge_no == edge_n;
    chk("mix_valid", int'(mix1), int'(exp_mv));
    chk("overrun", int'(ov1), int'(m_ovr));
    if (exp_mv) begin
      e = evq.pop_front();
      m_ch[e.ch] = e.prod;
      for (int i = 0; i < 4; i++) chk($sformatf("ch_out[%0d]", i), ch1v(i), m_ch[i]);
      chk("left", int'($signed(lf1)), m_ch[0] + m_ch[3]);
      chk("right", int'($signed(rt1)), m_ch[1] + m_ch[2]);
    end
    edge_n++;
    smp_req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp_req = 4'($urandom); smp_in = $urandom; vol_in = 24'($urandom); mute = 4'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst mix_valid", int'(mix1), 0);
    chk("rst ch_out", int'(co1 != 0), 0);
    chk("rst left", int'(lf1), 0);
    chk("rst right", int'(rt1), 0);
    chk("rst overrun", int'(ov1), 0);
    chk("rst mul_sample", int'(ms1), 0);
    chk("rst mul_volume", int'(mvol1), 0);
    smp_req = '0; mute = '0;
    model_reset();
    rst1 = 1'b1;
  endtask

  task automatic wait_mix1(input int budget, output int n);
    n = 0;
    while (!mix1 && n < budget) begin tick(); n++; end
    if (!mix1) chk("mix_valid timeout", 0, 1);
  endtask

  typedef struct {int ch; logic [7:0] smp; logic [5:0] vol; logic m; int prod; int lft; int rgt;} row_t;
  row_t tbl[8];

  initial begin
    int n, pulses, last_e, order[4];
    rst1 = 1'b0; rst3 = 1'b0;
    smp_req = '0; smp_in = '0; vol_in = '0; mute = '0;
    tbl[0] = '{0, 8'h80, 6'd63, 1'b0, -8064, -8064, 0};
    tbl[1] = '{1, 8'h7F, 6'd63, 1'b0,  8001, -8064, 8001};
    tbl[2] = '{2, 8'hFF, 6'd1,  1'b0,    -1, -8064, 8000};
    tbl[3] = '{3, 8'h10, 6'd2,  1'b0,    32, -8032, 8000};
    tbl[4] = '{1, 8'h40, 6'd10, 1'b1,     0, -8032, -1};
    tbl[5] = '{0, 8'h05, 6'd0,  1'b0,     0,    32, -1};
    tbl[6] = '{3, 8'h80, 6'd63, 1'b0, -8064, -8064, -1};
    tbl[7] = '{2, 8'h7F, 6'd63, 1'b0,  8001, -8064, 8001};

    // Reset, then idle: nothing may move without a request.
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    chk("idle mul_sample", int'(ms1), 0);

    // Single-channel table: latency MUL_LAT+2 ticks after the request edge.
    for (int r = 0; r < 8; r++) begin
      smp_in[8*tbl[r].ch +: 8] = tbl[r].smp;
      vol_in[6*tbl[r].ch +: 6] = tbl[r].vol;
      mute[tbl[r].ch] = tbl[r].m;
      smp_req[tbl[r].ch] = 1'b1;
      tick();
      wait_mix1(10, n);
      chk($sformatf("row%0d latency", r), n, L1 + 2);
      chk($sformatf("row%0d ch_out", r), ch1v(tbl[r].ch), tbl[r].prod);
      chk($sformatf("row%0d left", r), int'($signed(lf1)), tbl[r].lft);
      chk($sformatf("row%0d right", r), int'($signed(rt1)), tbl[r].rgt);
      mute = '0;
      tick();
    end

    // All four at once after reset: served 0,1,2,3, a pulse every MUL_LAT+2 cycles.
    do_reset();
    tick();
    smp_in = {8'h44, 8'h33, 8'h22, 8'h11};
    vol_in = {6'd4, 6'd3, 6'd2, 6'd1};
    order = '{17, 68, 153, 272};
    smp_req = 4'b1111;
    pulses = 0; last_e = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mix1) begin
        if (pulses < 4) chk($sformatf("simul ch_out[%0d]", pulses), ch1v(pulses), order[pulses]);
        if (last_e >= 0) chk("simul spacing", edge_n - last_e, L1 + 2);
        last_e = edge_n;
        pulses++;
      end
    end
    chk("simul pulses", pulses, 4);
    chk("simul left", int'($signed(lf1)), 289);
    chk("simul right", int'($signed(rt1)), 221);

    // Overrun: two ch2 requests while ch0 occupies the multiplier.
    smp_in[7:0] = 8'h01; vol_in[5:0] = 6'd1; smp_req = 4'b0001; tick();
    smp_in[23:16] = 8'h10; vol_in[17:12] = 6'd2; smp_req = 4'b0100; tick();
    smp_in[23:16] = 8'h20; smp_req = 4'b0100; tick();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (mix1) pulses++; end
    chk("ovr flags", int'(ov1), 4'b0100);
    chk("ovr ch_out[2]", ch1v(2), 64);
    chk("ovr pulses", pulses, 2);

    // Mute plus a request on ch1's own issue edge: served twice, no overrun.
    mute = 4'b0010; smp_in[15:8] = 8'h33; vol_in[11:6] = 6'd5; smp_req = 4'b0010; tick();
    smp_in[15:8] = 8'h02; vol_in[11:6] = 6'd3; smp_req = 4'b0010; tick();
    mute = '0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (mix1) begin
        pulses++;
        chk($sformatf("mute pulse%0d ch_out[1]", pulses), ch1v(1), pulses == 1 ? 0 : 6);
      end
    end
    chk("coincident pulses", pulses, 2);
    chk("coincident overrun[1]", int'(ov1[1]), 0);

    // MUL_LAT=3 instance: reset while BUSY aborts the product; ch0 priority after release.
    @(negedge clk); rst3 = 1'b1;
    tick(); tick();
    smp_in[23:16] = 8'h03; vol_in[17:12] = 6'd4; smp_req = 4'b0100;
    tick(); tick(); tick();
    rst3 = 1'b0;
    #1;
    chk("abort mul_sample", int'(ms3), 0);
    chk("abort mul_volume", int'(mvol3), 0);
    chk("abort ch_out", int'(co3 != 0), 0);
    chk("abort left/right", int'(lf3 != 0 || rt3 != 0), 0);
    chk("abort mix_valid", int'(mix3), 0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin tick(); if (mix3) pulses++; end
    rst3 = 1'b1;
    for (int c = 0; c < 8; c++) begin tick(); if (mix3) pulses++; end
    chk("abort no mix", pulses, 0);
    smp_in[7:0] = 8'h10; vol_in[5:0] = 6'd3; smp_in[31:24] = 8'h7F; vol_in[23:18] = 6'd1;
    smp_req = 4'b1001;
    tick();
    n = 0;
    while (!mix3 && n < 12) begin tick(); n++; end
    chk("lat3 latency", n, L3 + 2);
    chk("lat3 first ch_out[0]", ch3v(0), 48);
    chk("lat3 first ch_out[3]", ch3v(3), 0);
    chk("lat3 first left", int'($signed(lf3)), 48);
    tick();
    n = 0;
    while (!mix3 && n < 12) begin tick(); n++; end
    chk("lat3 second left", int'($signed(lf3)), 175);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      smp_in = $urandom;
      vol_in = 24'($urandom);
      mute = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) smp_req[i] = ($urandom_range(5) == 0);
      tick();
    end
    smp_req = '0;
    for (int c = 0; c < 30; c++) tick();
    chk("drained", evq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
